// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the game-counter sequencer.
//   state_e       : sequencer states
//   MODE_*        : counter control encodings
//   WHO_*         : WHO encodings reported by the counter
//   TALLY_W       : width of the win/lose tallies
//   sat_inc       : saturating tally increment
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] WHO_WIN  = 2'b10;
    localparam logic [1:0] WHO_LOSE = 2'b01;

    localparam int unsigned TALLY_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == '1) ? v : v + TALLY_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   i_req    : request vector
//   i_ptr    : index of the previous winner; search starts at i_ptr+1
//   o_onehot : one-hot winner (zero when no request)
//   o_idx    : winner index
//   o_valid  : some request was found
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    int unsigned w_j;

    // Walk ptr+1 .. ptr+NREQ (wrapping) so the previous winner is tried last.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_j      = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_j = 32'(i_ptr) + i;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!o_valid && i_req[IW'(w_j)]) begin
                o_valid              = 1'b1;
                o_onehot[IW'(w_j)]   = 1'b1;
                o_idx                = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/counter_game_ctrl.sv
// Time-slice sequencer for the shared game counter.
//   clk, reset     : clock, asynchronous active-low reset
//   req*           : per-requester request, mode, seed and seed enable
//   gameover, who  : status from the counter
//   grant          : one-hot current owner
//   ctrl_*         : mode / INIT / initial value / sync reset to the counter
//   busy           : sequencer not idle
//   win/lose_tally : saturating game-over tallies
module counter_game_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned SLICE = 8,
    parameter int unsigned COOL  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_mode,
    input  logic [4*NREQ-1:0]   req_seed,
    input  logic [NREQ-1:0]     req_seed_en,
    input  logic                gameover,
    input  logic [1:0]          who,
    output logic [NREQ-1:0]     grant,
    output logic [1:0]          ctrl_mode,
    output logic                ctrl_init,
    output logic [3:0]          ctrl_value,
    output logic                ctrl_reset,
    output logic                busy,
    output logic [TALLY_W-1:0]  win_tally,
    output logic [TALLY_W-1:0]  lose_tally
);

    localparam int unsigned IW = (NREQ  > 1) ? $clog2(NREQ)  : 1;
    localparam int unsigned SW = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int unsigned CW = (COOL  > 1) ? $clog2(COOL)  : 1;

    state_e              r_state,  w_nx_state;
    logic [NREQ-1:0]     r_grant,  w_nx_grant;
    logic [1:0]          r_mode,   w_nx_mode;
    logic                r_init,   w_nx_init;
    logic [3:0]          r_value,  w_nx_value;
    logic                r_creset, w_nx_creset;
    logic                r_busy,   w_nx_busy;
    logic [TALLY_W-1:0]  r_win,    w_nx_win;
    logic [TALLY_W-1:0]  r_lose,   w_nx_lose;
    logic [IW-1:0]       r_ptr,    w_nx_ptr;
    logic [SW-1:0]       r_slice,  w_nx_slice;
    logic [CW-1:0]       r_cool,   w_nx_cool;

    logic [NREQ-1:0]     w_arb_onehot;
    logic [IW-1:0]       w_arb_idx;
    logic                w_arb_valid;
    logic [1:0]          w_own_mode;
    logic [3:0]          w_arb_seed;
    logic                w_arb_seed_en;

    // r_ptr doubles as the current owner index while a grant is held.
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_arb_onehot),
        .o_idx    (w_arb_idx),
        .o_valid  (w_arb_valid)
    );

    assign w_own_mode    = req_mode[{r_ptr, 1'b0} +: 2];
    assign w_arb_seed    = req_seed[{w_arb_idx, 2'b00} +: 4];
    assign w_arb_seed_en = req_seed_en[w_arb_idx];

    // Next-state and next-output computation.
    always_comb begin
        w_nx_state  = r_state;
        w_nx_grant  = r_grant;
        w_nx_mode   = r_mode;
        w_nx_init   = 1'b0;
        w_nx_value  = r_value;
        w_nx_creset = 1'b0;
        w_nx_win    = r_win;
        w_nx_lose   = r_lose;
        w_nx_ptr    = r_ptr;
        w_nx_slice  = r_slice;
        w_nx_cool   = r_cool;

        case (r_state)
            ST_IDLE: begin
                w_nx_grant = '0;
                w_nx_mode  = MODE_UP1;
                if (w_arb_valid) begin
                    w_nx_state = ST_LOAD;
                    w_nx_ptr   = w_arb_idx;
                    w_nx_grant = w_arb_onehot;
                    if (w_arb_seed_en) begin
                        w_nx_init  = 1'b1;
                        w_nx_value = w_arb_seed;
                    end
                end
            end
            ST_LOAD: begin
                w_nx_state = ST_RUN;
                w_nx_mode  = w_own_mode;
                w_nx_slice = SW'(SLICE - 1);
            end
            ST_RUN: begin
                w_nx_mode  = w_own_mode;
                w_nx_slice = r_slice - SW'(1);
                if (gameover) begin
                    w_nx_state  = ST_DONE;
                    w_nx_grant  = '0;
                    w_nx_mode   = MODE_UP1;
                    w_nx_creset = 1'b1;
                    w_nx_cool   = CW'(COOL - 1);
                    if (who == WHO_WIN)  w_nx_win  = sat_inc(r_win);
                    if (who == WHO_LOSE) w_nx_lose = sat_inc(r_lose);
                end else if (!req[r_ptr]) begin
                    w_nx_state = ST_IDLE;
                    w_nx_grant = '0;
                    w_nx_mode  = MODE_UP1;
                end else if (r_slice == '0) begin
                    // Arbiter tries the owner last, so a different index means a rival is waiting.
                    if (w_arb_valid && (w_arb_idx != r_ptr)) begin
                        w_nx_state = ST_LOAD;
                        w_nx_ptr   = w_arb_idx;
                        w_nx_grant = w_arb_onehot;
                        if (w_arb_seed_en) begin
                            w_nx_init  = 1'b1;
                            w_nx_value = w_arb_seed;
                        end
                    end else begin
                        w_nx_slice = SW'(SLICE - 1);
                    end
                end
            end
            ST_DONE: begin
                w_nx_grant = '0;
                w_nx_mode  = MODE_UP1;
                if (r_cool == '0) w_nx_state = ST_IDLE;
                else              w_nx_cool  = r_cool - CW'(1);
            end
            default: w_nx_state = ST_IDLE;
        endcase

        w_nx_busy = (w_nx_state != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_mode   <= MODE_UP1;
            r_init   <= 1'b0;
            r_value  <= '0;
            r_creset <= 1'b1;
            r_busy   <= 1'b0;
            r_win    <= '0;
            r_lose   <= '0;
            r_ptr    <= IW'(NREQ - 1);
            r_slice  <= '0;
            r_cool   <= '0;
        end else begin
            r_state  <= w_nx_state;
            r_grant  <= w_nx_grant;
            r_mode   <= w_nx_mode;
            r_init   <= w_nx_init;
            r_value  <= w_nx_value;
            r_creset <= w_nx_creset;
            r_busy   <= w_nx_busy;
            r_win    <= w_nx_win;
            r_lose   <= w_nx_lose;
            r_ptr    <= w_nx_ptr;
            r_slice  <= w_nx_slice;
            r_cool   <= w_nx_cool;
        end
    end

    assign grant      = r_grant;
    assign ctrl_mode  = r_mode;
    assign ctrl_init  = r_init;
    assign ctrl_value = r_value;
    assign ctrl_reset = r_creset;
    assign busy       = r_busy;
    assign win_tally  = r_win;
    assign lose_tally = r_lose;

endmodule

// File: doc/counter_game_ctrl.md
# counter_game_ctrl

Sequencer and arbiter for the multi-mode game counter. It shares the one counter between `NREQ` requesters in round-robin time slices, drives the counter's mode, INIT and initial value, and watches GAMEOVER/WHO. When a game ends it forces a counter reset and a cool-down, and it keeps saturating win/lose tallies. It sits between the requester logic and the counter instance.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `SLICE`, 8: RUN cycles per grant before handover (>=1).
- `COOL`, 4: cycles spent in DONE after a game over (>=1).
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, NREQ: requester i wants ownership of the counter.
- `req_mode`, in, 2*NREQ: mode of requester i in bits [2i+1:2i]. 00 = up 1, 01 = up 2, 10 = down 1, 11 = down 2.
- `req_seed`, in, 4*NREQ: preload value of requester i in bits [4i+3:4i].
- `req_seed_en`, in, NREQ: requester i wants a preload at grant.
- `gameover`, in, 1: GAMEOVER from the counter.
- `who`, in, 2: WHO from the counter. 10 = winner, 01 = loser.
- `grant`, out, NREQ: one-hot owner; all zero when no owner.
- `ctrl_mode`, out, 2: drives the counter's control input.
- `ctrl_init`, out, 1: drives INIT.
- `ctrl_value`, out, 4: drives initial_value.
- `ctrl_reset`, out, 1: drives the counter's synchronous active-high reset.
- `busy`, out, 1: state is not IDLE.
- `win_tally`, out, 8: count of game overs with who=10; saturates at 255.
- `lose_tally`, out, 8: count of game overs with who=01; saturates at 255.

## Operation
- **FSM states:** IDLE, LOAD, RUN, DONE.
- **All outputs registered.** Reset values:
  - state IDLE, `grant` 0, `ctrl_mode` 00, `ctrl_init` 0, `ctrl_value` 0
  - `ctrl_reset` 1, so the counter is cleared on the first edge after reset release
  - `busy` 0, tallies 0, round-robin pointer NREQ-1 (requester 0 wins first)
- **IDLE:**
  - `grant` 0, `ctrl_mode` 00, `ctrl_init` 0.
  - If `req` is nonzero, pick the first set bit searching upward from pointer+1 (wrapping), load the pointer with that index, go to LOAD.
- **LOAD (1 cycle):**
  - `grant` is set to the owner g.
  - If `req_seed_en[g]`: `ctrl_init` = 1 and `ctrl_value` = `req_seed[g]`. Otherwise `ctrl_init` = 0.
  - Load the slice counter with SLICE-1. Go to RUN.
- **RUN:**
  - `ctrl_mode` = `req_mode[g]`, sampled every cycle.
  - `ctrl_init` = 0. The slice counter decrements each cycle.
  - Exits, highest priority first:
    1. `gameover`: go to DONE.
    2. `req[g]` = 0: owner released, go to IDLE.
    3. Slice counter = 0 and some other `req` set: hand over straight to LOAD with the next round-robin winner.
    4. Slice counter = 0 and no other request: reload SLICE-1 and stay in RUN with the same owner.
- **DONE:**
  - `grant` 0, `ctrl_mode` 00.
  - `ctrl_reset` = 1 on the first DONE cycle only.
  - Tally update happens on the RUN→DONE edge, using `who` sampled together with `gameover`. who=00/11 updates neither tally.
  - Stay COOL cycles, then go to IDLE.
  - `gameover` and `req` are ignored while in DONE.
- **Outside RUN:** `gameover` is ignored and the tallies are unchanged.
- **Tallies** hold at 255 (no wrap). The slice counter width is clog2(SLICE) with a minimum of 1.

## Timing
- `req` sampled at edge k in IDLE → `grant` and `ctrl_init` high during cycle k+1 (LOAD) → RUN from edge k+2.
- With no events, an owner holds RUN for exactly SLICE cycles before handover. Handover goes RUN → LOAD → RUN and gives a 1-cycle `ctrl_init` gap.
- `gameover` high at edge k in RUN → `grant` 0 and `ctrl_reset` 1 after edge k. Tally is visible after edge k; DONE lasts edges k+1..k+COOL; IDLE after edge k+COOL.
- If `gameover` and owner release happen on the same edge, `gameover` wins.
- Reset asserted mid-game: all outputs go to reset values immediately (asynchronous); tallies are lost.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the state enum
  - mode constants MODE_UP1/UP2/DN1/DN2
  - WHO_WIN = 2'b10, WHO_LOSE = 2'b01
  - the tally width constant (8)
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and the pointer, producing a one-hot result and an index.

## Test plan
- Reset release, `req` = 01 with `req_seed_en[0]` = 1 and seed 4'h9 → `ctrl_reset` drops at the first edge; LOAD with `ctrl_init` = 1 and `ctrl_value` = 9; RUN with `grant` = 01.
- `req` = 11 held, SLICE = 8 → `grant` alternates 01, 10, 01, with 8 RUN cycles plus 1 LOAD per turn.
- In RUN, `gameover` = 1 with `who` = 10 → `win_tally` = 1, `grant` 0, a single `ctrl_reset` pulse, 4 DONE cycles, then IDLE.
- `gameover` with `who` = 01 on the same edge as `req[g]` falling → DONE is entered and `lose_tally` = 1.
- 256 consecutive game overs with `who` = 10 → `win_tally` holds at 255.
- `reset` asserted mid-RUN, off the clock edge → `grant` = 0, `ctrl_reset` = 1 and tallies = 0 with no clock edge.
